snax_simbacore_csr_launcher: RTL and testbench
==============================================

# snax_simbacore_csr_launcher

Sequences packed CSR configurations from the SimbaCore CSR manager wrapper into the SimbaCore datapath. Sits directly downstream of the CSR manager's read-write set/valid/ready port and directly upstream of the accelerator core. Holds one pending configuration while a job runs, then launches it. Returns status and performance words on the CSR manager's read-only inputs.

## Interface
- NumRwCsr, 5, number of 32-bit read-write CSRs per configuration
- NumRoCsr, 2, number of 32-bit read-only CSRs returned (fixed at 2 by this block)
- Clocking and reset: one clock; reset is asynchronous and active-high.
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- csr_reg_rw_set_i  in  NumRwCsr×32  configuration from CSR manager
- csr_reg_set_valid_i  in  1  configuration valid
- csr_reg_set_ready_o  out  1  configuration accepted
- csr_reg_ro_set_o  out  NumRoCsr×32  status (0) and last-job cycle count (1)
- core_cfg_o  out  NumRwCsr×32  active configuration, stable from launch until done
- core_start_valid_o  out  1  start request to core
- core_start_ready_i  in  1  core accepts start
- core_done_i  in  1  single-cycle job completion pulse

## Operation
- Pending slot (pend_q, pend_vld_q) and active register (act_q).
- Accept: csr_reg_set_ready_o = ~pend_vld_q. On valid&ready, pend_q ← csr_reg_rw_set_i, pend_vld_q ← 1.
- FSM states: IDLE, LAUNCH, BUSY.
  - IDLE: if pend_vld_q, act_q ← pend_q, pend_vld_q ← 0, go LAUNCH.
  - LAUNCH: core_start_valid_o = 1. On core_start_ready_i go BUSY.
  - BUSY: on core_done_i, if pend_vld_q, copy pending→active, clear pend_vld_q, go LAUNCH. Otherwise go IDLE.
- core_cfg_o = act_q at all times.
- Status word csr_reg_ro_set_o[0]:
  - bit0 busy (state ≠ IDLE)
  - bit1 pend_vld_q
  - bit2 sticky spurious_done: core_done_i seen in IDLE or LAUNCH; cleared only by reset
  - bits[15:3] zero
  - bits[31:16] job counter: increments on each done in BUSY; wraps 0xFFFF→0
- core_done_i outside BUSY is otherwise ignored: no state change, no counter change.

## Timing
- Reset values:
  - csr_reg_set_ready_o = 1
  - core_start_valid_o = 0
  - core_cfg_o = 0
  - csr_reg_ro_set_o = 0
  - state IDLE
  - all counters 0
- Latency from an idle block:
  - Accept at edge k.
  - Copy to active at edge k+1.
  - core_start_valid_o high during cycle k+1→k+2, i.e. first visible after edge k+1.
- Start handshake:
  - core_start_valid_o stays high until core_start_ready_i; it never drops without ready.
  - core_cfg_o does not change while valid is high.
- Back-to-back jobs: done at edge d with a pending config gives core_start_valid_o after edge d, with zero idle cycles. csr_reg_set_ready_o rises after edge d.
- Pending full: ready is low. A new valid waits; there is no drop and no overwrite.
- Ready is registered-derived. It does not depend combinationally on csr_reg_set_valid_i.
- Simultaneous accept and copy cannot occur, because ready is low whenever the slot is occupied.
- Reset mid-job: all state clears immediately. The core must be reset alongside.

## Configuration
- Macro: SNAX_SIMBACORE_CSR_LAUNCHER_PERF_EN
- Defined:
  - Cycle counter counts every cycle spent in LAUNCH or BUSY for the current job, including the done cycle.
  - Counter starts at 1 on entering LAUNCH and saturates at 0xFFFFFFFF.
  - Value is latched into csr_reg_ro_set_o[1] on the done edge; it holds until the next done.
- Undefined: no counter logic; csr_reg_ro_set_o[1] is tied to 0.

## Structure
- Shared package snax_simbacore_csr_launcher_pkg:
  - state enum (IDLE, LAUNCH, BUSY)
  - status bit-position constants
  - cfg_t as packed NumRwCsr×32 array
- Optional sub-module snax_simbacore_perf_counter: saturating 32-bit counter with clear, enable and latch. Instantiated only under the macro.

## Test plan
- Reset released, single config {1,2,3,4,5} with core_start_ready_i tied 1:
  - start_valid asserted one cycle, at edge k+1 after accept
  - core_cfg_o = {1,2,3,4,5}
  - status = 0x0000_0001 while busy
- Core takes 10 cycles to done, perf enabled:
  - ro[1] = 11 after done
  - status = 0x0001_0000
- Second config sent while first runs:
  - accepted, then ready low
  - third valid is stalled until first done
  - second launches with no idle cycle
  - job counter reaches 2
- core_start_ready_i held 0 for 5 cycles:
  - start_valid stays high
  - cfg stable
  - BUSY entered only on the ready cycle
- core_done_i pulsed in IDLE: status bit2 = 1, job counter unchanged, state IDLE.
- Reset asserted during BUSY with pending valid: all outputs return to reset values asynchronously; ready = 1.

Source files
------------

// File: rtl/snax_simbacore_csr_launcher_pkg.sv
// Shared types and constants for the SimbaCore CSR launcher: FSM states,
// status-word bit positions and the packed configuration type.
package snax_simbacore_csr_launcher_pkg;

    localparam int unsigned NumRwCsr = 5;
    localparam int unsigned NumRoCsr = 2;

    localparam int unsigned StatusBusyBit = 0;
    localparam int unsigned StatusPendBit = 1;
    localparam int unsigned StatusSpurBit = 2;
    localparam int unsigned StatusJobLsb  = 16;

    typedef logic [NumRwCsr-1:0][31:0] cfg_t;
    typedef logic [NumRoCsr-1:0][31:0] ro_t;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        BUSY
    } state_e;

endpackage

// File: rtl/snax_simbacore_perf_counter.sv
// Saturating 32-bit job cycle counter with clear-to-one, enable and latch.
// Only compiled when SNAX_SIMBACORE_CSR_LAUNCHER_PERF_EN is defined.
`ifdef SNAX_SIMBACORE_CSR_LAUNCHER_PERF_EN
module snax_simbacore_perf_counter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        enable_i,
    input  logic        latch_i,
    output logic [31:0] latched_o
);

    logic [31:0] count_q;

    // Clearing loads 1 so the count already includes the cycle being entered.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= 32'd1;
        end else if (enable_i && (count_q != 32'hFFFF_FFFF)) begin
            count_q <= count_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            latched_o <= '0;
        end else if (latch_i) begin
            latched_o <= count_q;
        end
    end

endmodule
`endif

// File: rtl/snax_simbacore_csr_launcher.sv
// Buffers one CSR configuration and launches it into the SimbaCore datapath.
// Define SNAX_SIMBACORE_CSR_LAUNCHER_PERF_EN to report per-job cycle counts.
module snax_simbacore_csr_launcher
    import snax_simbacore_csr_launcher_pkg::*;
(
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NumRwCsr-1:0][31:0]   csr_reg_rw_set_i,
    input  logic                        csr_reg_set_valid_i,
    output logic                        csr_reg_set_ready_o,
    output logic [NumRoCsr-1:0][31:0]   csr_reg_ro_set_o,
    output logic [NumRwCsr-1:0][31:0]   core_cfg_o,
    output logic                        core_start_valid_o,
    input  logic                        core_start_ready_i,
    input  logic                        core_done_i
);

    state_e      state_q, state_d;
    cfg_t        pend_q, act_q;
    logic        pend_vld_q;
    logic        spurious_q;
    logic [15:0] job_cnt_q;
    logic        accept;
    logic        load_act;
    logic        job_done;
    logic [31:0] status_word;
    logic [31:0] perf_word;

    assign csr_reg_set_ready_o = ~pend_vld_q;
    assign accept              = csr_reg_set_valid_i & ~pend_vld_q;
    assign job_done            = (state_q == BUSY) & core_done_i;
    assign core_cfg_o          = act_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        load_act           = 1'b0;
        core_start_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend_vld_q) begin
                    load_act = 1'b1;
                    state_d  = LAUNCH;
                end
            end
            LAUNCH: begin
                core_start_valid_o = 1'b1;
                if (core_start_ready_i) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // A waiting config launches on the done edge with no idle gap.
                if (core_done_i) begin
                    if (pend_vld_q) begin
                        load_act = 1'b1;
                        state_d  = LAUNCH;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            act_q      <= '0;
            job_cnt_q  <= '0;
            spurious_q <= 1'b0;
        end else begin
            if (accept) begin
                pend_q     <= csr_reg_rw_set_i;
                pend_vld_q <= 1'b1;
            end else if (load_act) begin
                pend_vld_q <= 1'b0;
            end
            if (load_act) begin
                act_q <= pend_q;
            end
            if (job_done) begin
                job_cnt_q <= job_cnt_q + 16'd1;
            end
            if (core_done_i && (state_q != BUSY)) begin
                spurious_q <= 1'b1;
            end
        end
    end

    always_comb begin
        status_word                          = '0;
        status_word[StatusBusyBit]           = (state_q != IDLE);
        status_word[StatusPendBit]           = pend_vld_q;
        status_word[StatusSpurBit]           = spurious_q;
        status_word[StatusJobLsb +: 16]      = job_cnt_q;
    end

`ifdef SNAX_SIMBACORE_CSR_LAUNCHER_PERF_EN
    snax_simbacore_perf_counter i_perf_counter (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (load_act),
        .enable_i  (state_q != IDLE),
        .latch_i   (job_done),
        .latched_o (perf_word)
    );
`else
    assign perf_word = '0;
`endif

    assign csr_reg_ro_set_o = {perf_word, status_word};

endmodule

// File: tb/tb_snax_simbacore_csr_launcher.sv
// Self-checking bench for snax_simbacore_csr_launcher: directed scenarios
// followed by randomized traffic, all checked against a job-level model.
module tb_snax_simbacore_csr_launcher;
    import snax_simbacore_csr_launcher_pkg::*;

    logic clk = 1'b0;
    logic rst;
    cfg_t rw_set;
    logic set_valid;
    logic set_ready;
    ro_t  ro_set;
    cfg_t core_cfg;
    logic start_valid;
    logic start_ready;
    logic core_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    snax_simbacore_csr_launcher dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .csr_reg_rw_set_i    (rw_set),
        .csr_reg_set_valid_i (set_valid),
        .csr_reg_set_ready_o (set_ready),
        .csr_reg_ro_set_o    (ro_set),
        .core_cfg_o          (core_cfg),
        .core_start_valid_o  (start_valid),
        .core_start_ready_i  (start_ready),
        .core_done_i         (core_done)
    );

    // Job-level model: a queue of accepted-but-not-launched configs, the job
    // in flight (waiting for start or running) and its elapsed cycle count.
    cfg_t            waiting[$];
    cfg_t            m_act;
    bit              m_launching;
    bit              m_running;
    bit              m_spur;
    int unsigned     m_jobs;
    longint unsigned m_cycles;
    logic [31:0]     m_perf;

    function automatic logic [31:0] sat32(longint unsigned v);
        logic [63:0] w;
        w = v;
        return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : w[31:0];
    endfunction

    function automatic cfg_t make_cfg(int unsigned base);
        cfg_t c;
        for (int i = 0; i < NumRwCsr; i++) c[i] = base + i;
        return c;
    endfunction

    task automatic model_reset();
        waiting.delete();
        m_act       = '0;
        m_launching = 1'b0;
        m_running   = 1'b0;
        m_spur      = 1'b0;
        m_jobs      = 0;
        m_cycles    = 0;
        m_perf      = '0;
    endtask

    task automatic model_edge();
        bit   acc;
        cfg_t incoming;
        acc      = set_valid && (waiting.size() == 0);
        incoming = rw_set;
        if (core_done && !m_running) m_spur = 1'b1;
        if (m_running && core_done) begin
            m_jobs    = m_jobs + 1;
            m_perf    = sat32(m_cycles);
            m_running = 1'b0;
        end else if (m_launching) begin
            if (start_ready) begin
                m_launching = 1'b0;
                m_running   = 1'b1;
            end
            m_cycles++;
        end else if (m_running) begin
            m_cycles++;
        end
        if (!m_launching && !m_running && (waiting.size() > 0)) begin
            m_act       = waiting.pop_front();
            m_launching = 1'b1;
            m_cycles    = 1;
        end
        if (acc) waiting.push_back(incoming);
    endtask

    task automatic check(string name, logic [159:0] actual, logic [159:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic check_output();
        logic [31:0] exp_status;
        logic [31:0] exp_perf;
        logic [31:0] jobs_w;
        jobs_w     = m_jobs;
        exp_status = {jobs_w[15:0], 13'b0, m_spur, (waiting.size() != 0), (m_launching || m_running)};
`ifdef SNAX_SIMBACORE_CSR_LAUNCHER_PERF_EN
        exp_perf = m_perf;
`else
        exp_perf = '0;
`endif
        check("ready", set_ready, waiting.size() == 0);
        check("start_valid", start_valid, m_launching);
        check("core_cfg", core_cfg, m_act);
        check("status", ro_set[0], exp_status);
        check("perf", ro_set[1], exp_perf);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rst) model_edge();
        @(negedge clk);
        check_output();
    endtask

    task automatic apply_stimulus(int unsigned n);
        for (int i = 0; i < n; i++) begin
            set_valid   = ($urandom_range(0, 99) < 50);
            rw_set      = make_cfg($urandom);
            start_ready = ($urandom_range(0, 99) < 60);
            core_done   = m_running ? ($urandom_range(0, 99) < 20) : ($urandom_range(0, 99) < 2);
            cycle();
        end
        set_valid = 1'b0;
        core_done = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        rw_set      = '0;
        set_valid   = 1'b0;
        start_ready = 1'b0;
        core_done   = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_output();
        check("reset_ready", set_ready, 1'b1);
        check("reset_status", ro_set[0], 32'h0);
        rst = 1'b0;

        // Single job, start accepted immediately, done on the 10th busy cycle.
        rw_set = make_cfg(1); set_valid = 1'b1; start_ready = 1'b1;
        cycle();
        set_valid = 1'b0;
        check("accept_ready_low", set_ready, 1'b0);
        cycle();
        check("launch_valid", start_valid, 1'b1);
        check("launch_cfg", core_cfg, {32'd5, 32'd4, 32'd3, 32'd2, 32'd1});
        check("launch_status", ro_set[0], 32'h0000_0001);
        cycle();
        check("valid_one_cycle", start_valid, 1'b0);
        check("busy_status", ro_set[0], 32'h0000_0001);
        repeat (9) cycle();
        core_done = 1'b1;
        cycle();
        core_done = 1'b0;
        check("done_status", ro_set[0], 32'h0001_0000);
`ifdef SNAX_SIMBACORE_CSR_LAUNCHER_PERF_EN
        check("done_perf", ro_set[1], 32'd11);
`else
        check("done_perf", ro_set[1], 32'd0);
`endif

        // Second config queued behind a running job, third one stalled.
        rw_set = make_cfg(10); set_valid = 1'b1;
        cycle();
        set_valid = 1'b0;
        cycle();
        cycle();
        rw_set = make_cfg(20); set_valid = 1'b1;
        cycle();
        check("second_ready_low", set_ready, 1'b0);
        rw_set = make_cfg(30);
        repeat (3) begin
            cycle();
            check("third_stalled", set_ready, 1'b0);
        end
        core_done = 1'b1;
        cycle();
        core_done = 1'b0;
        check("b2b_valid", start_valid, 1'b1);
        check("b2b_cfg", core_cfg, make_cfg(20));
        check("b2b_ready", set_ready, 1'b1);
        check("b2b_jobs", ro_set[0][31:16], 16'd2);

        // Start handshake held off for five cycles.
        start_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            set_valid = 1'b0;
            check("hold_valid", start_valid, 1'b1);
            check("hold_cfg", core_cfg, make_cfg(20));
        end
        start_ready = 1'b1;
        cycle();
        check("busy_on_ready", start_valid, 1'b0);
        repeat (3) cycle();
        core_done = 1'b1;
        cycle();
        core_done = 1'b0;
        check("third_launch_cfg", core_cfg, make_cfg(30));
        repeat (2) cycle();
        core_done = 1'b1;
        cycle();
        check("jobs_idle", ro_set[0], 32'h0004_0000);

        // Done while idle only raises the sticky flag.
        cycle();
        core_done = 1'b0;
        check("spurious_status", ro_set[0], 32'h0004_0004);
        check("spurious_no_start", start_valid, 1'b0);

        // Asynchronous reset while busy with a pending config.
        rw_set = make_cfg(40); set_valid = 1'b1;
        cycle();
        set_valid = 1'b0;
        cycle();
        cycle();
        rw_set = make_cfg(50); set_valid = 1'b1;
        cycle();
        set_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_ready", set_ready, 1'b1);
        check("async_valid", start_valid, 1'b0);
        check("async_cfg", core_cfg, '0);
        check("async_status", ro_set[0], 32'h0);
        check("async_perf", ro_set[1], 32'h0);
        model_reset();
        @(negedge clk);
        check_output();
        rst = 1'b0;

        apply_stimulus(3000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
